pipe_ctrl: RTL

- Central stall/flush sequencer for the six-stage pipeline (PC, IF, ID, EX, MEM, WB).
- Collects per-stage stall requests and exception/ERET events. Drives the shared pause[5:0] vector and clear line consumed by every pipeline register, including the MEM/WB register, and supplies the redirect PC.
- Defers a flush while an unabortable MEM bus transaction is outstanding.

---
 rtl/pipe_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl - stall/flush sequencer for the six-stage pipeline
// (PC, IF, ID, EX, MEM, WB).
//
// Collects per-stage stall requests and exception/ERET events, drives the
// shared pause vector and clear line seen by every pipeline register, and
// supplies the redirect PC. A flush is deferred while an unabortable MEM
// bus transaction is outstanding.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   stallreq_if/id/ex/mem  per-stage stall requests
//   mem_busy          MEM bus transaction in flight (flush must wait)
//   excp_valid        exception/ERET committed at MEM this cycle
//   excp_is_eret      qualifies excp_valid as ERET (highest priority)
//   excp_tlb_refill   qualifies excp_valid as TLB refill
//   cp0_ebase         exception base
//   cp0_epc           ERET return address
//   pause[5:0]        stall vector, bit0=PC ... bit5=WB
//   clear             flush all pipeline registers
//   new_pc            redirect target, valid while clear=1
//   stall_cycles      stall performance counter
//
// Optional feature macro: PIPE_CTRL_STALL_CNT_EN
//   defined   -> stall_cycles counts edges with pause[0]=1 and clear=0
//   undefined -> stall_cycles tied to zero, no counter flops

module pipe_ctrl #(
  parameter logic [31:0] EXC_OFFSET    = 32'h0000_0180,
  parameter logic [31:0] REFILL_OFFSET = 32'h0000_0000,
  parameter int unsigned FLUSH_HOLD    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        mem_busy,
  input  logic        excp_valid,
  input  logic        excp_is_eret,
  input  logic        excp_tlb_refill,
  input  logic [31:0] cp0_ebase,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  pause,
  output logic        clear,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_MEM = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  // FLUSH state covers the clear cycles after the first one.
  localparam logic [2:0] HOLD_INIT = 3'(FLUSH_HOLD - 1);
  localparam logic       HOLD_MULTI = (FLUSH_HOLD > 1);

  state_t      r_state, w_state_next;
  logic [2:0]  r_hold, w_hold_next;
  logic [31:0] r_target, w_target_next;
  logic [31:0] w_target;
  logic [5:0]  w_pause;
  logic        w_clear;
  logic [31:0] w_new_pc;

  always_comb begin
    if (excp_is_eret)
      w_target = cp0_epc;
    else if (excp_tlb_refill)
      w_target = cp0_ebase + REFILL_OFFSET;
    else
      w_target = cp0_ebase + EXC_OFFSET;
  end

  always_comb begin
    w_state_next  = r_state;
    w_hold_next   = r_hold;
    w_target_next = r_target;
    w_pause       = '0;
    w_clear       = 1'b0;
    w_new_pc      = '0;
    unique case (r_state)
      RUN: begin
        if (excp_valid) begin
          w_target_next = w_target;
          if (mem_busy) begin
            w_pause      = '1;
            w_state_next = WAIT_MEM;
          end else begin
            w_clear  = 1'b1;
            w_new_pc = w_target;
            if (HOLD_MULTI) begin
              w_state_next = FLUSH;
              w_hold_next  = HOLD_INIT;
            end
          end
        end else if (stallreq_mem) begin
          w_pause = 6'b011111;
        end else if (stallreq_ex) begin
          w_pause = 6'b001111;
        end else if (stallreq_id) begin
          w_pause = 6'b000111;
        end else if (stallreq_if) begin
          w_pause = 6'b000011;
        end
      end
      WAIT_MEM: begin
        if (mem_busy) begin
          w_pause = '1;
        end else begin
          w_clear  = 1'b1;
          w_new_pc = r_target;
          if (HOLD_MULTI) begin
            w_state_next = FLUSH;
            w_hold_next  = HOLD_INIT;
          end else begin
            w_state_next = RUN;
          end
        end
      end
      FLUSH: begin
        w_clear     = 1'b1;
        w_new_pc    = r_target;
        w_hold_next = r_hold - 3'd1;
        if (r_hold <= 3'd1)
          w_state_next = RUN;
      end
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= RUN;
      r_hold   <= '0;
      r_target <= '0;
    end else begin
      r_state  <= w_state_next;
      r_hold   <= w_hold_next;
      r_target <= w_target_next;
    end
  end

  // Outputs are combinational from state and inputs; force them low
  // while reset is asserted so stall requests cannot leak through.
  assign pause  = rst ? '0 : w_pause;
  assign clear  = rst ? 1'b0 : w_clear;
  assign new_pc = rst ? '0 : w_new_pc;

`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (pause[0] && !clear)
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cycles = r_stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule
